// File: rtl/irq_ctrl_pkg.sv
// rtl/irq_ctrl_pkg.sv - shared constants, register map and FSM encoding for irq_ctrl
package irq_ctrl_pkg;

   localparam int NSRC_DEFAULT = 6;

   localparam logic [1:0] ADDR_MASK  = 2'd0;
   localparam logic [1:0] ADDR_MODE  = 2'd1;
   localparam logic [1:0] ADDR_PEND  = 2'd2;
   localparam logic [1:0] ADDR_INSVC = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_SVC  = 2'd2
   } state_t;

endpackage

// File: rtl/irq_ctrl_if.sv
// rtl/irq_ctrl_if.sv - word register access bus for irq_ctrl
interface irq_ctrl_if;

   logic [1:0]  addr;
   logic        we;
   logic [31:0] wd;
   logic [31:0] rd;

   modport master (output addr, output we, output wd, input rd);
   modport slave  (input addr, input we, input wd, output rd);

endinterface

// File: rtl/irq_prio_enc.sv
// rtl/irq_prio_enc.sv - lowest-index-wins one-hot priority select
module irq_prio_enc #(
   parameter int NSRC = 6
) (
   input  logic [NSRC-1:0] i_req,
   output logic [NSRC-1:0] o_onehot,
   output logic            o_valid
);

   logic [NSRC-1:0] w_neg;

   // Two's complement isolates the lowest set bit.
   assign w_neg    = ~i_req + {{(NSRC-1){1'b0}}, 1'b1};
   assign o_onehot = i_req & w_neg;
   assign o_valid  = |i_req;

endmodule

// File: rtl/irq_ctrl.sv
// rtl/irq_ctrl.sv - prioritised interrupt controller feeding CP0 HWInt
module irq_ctrl
   import irq_ctrl_pkg::*;
#(
   parameter int NSRC = NSRC_DEFAULT
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [NSRC-1:0] irq_in,
   irq_ctrl_if.slave       bus,
   input  logic            exc_handle,
   input  logic            eret,
   output logic [NSRC-1:0] hw_int
);

   logic [NSRC-1:0] r_mask;
   logic [NSRC-1:0] r_mode;
   logic [NSRC-1:0] r_pend_edge;
   logic [NSRC-1:0] r_insvc;
   logic [NSRC-1:0] r_irq_q;
   logic [NSRC-1:0] r_hw_int;
   state_t          r_state;

   state_t          w_state_nxt;
   logic [NSRC-1:0] w_hw_nxt;
   logic [NSRC-1:0] w_rise;
   logic [NSRC-1:0] w_pend;
   logic [NSRC-1:0] w_cand;
   logic [NSRC-1:0] w_sel;
   logic [NSRC-1:0] w_pend_set;
   logic [NSRC-1:0] w_pend_clr;
   logic            w_valid;
   logic            w_insvc_load;
   logic            w_insvc_clr;
   logic            w_wr_mask;
   logic            w_wr_mode;
   logic            w_wr_pend;

   assign w_wr_mask = bus.we && (bus.addr == ADDR_MASK);
   assign w_wr_mode = bus.we && (bus.addr == ADDR_MODE);
   assign w_wr_pend = bus.we && (bus.addr == ADDR_PEND);

   // Edge sources keep a sticky bit; level sources mirror the synchronised line.
   assign w_rise     = irq_in & ~r_irq_q;
   assign w_pend     = (r_pend_edge & r_mode) | (r_irq_q & ~r_mode);
   assign w_cand     = w_pend & r_mask;
   assign w_pend_set = w_rise & r_mode;
   assign w_pend_clr = ((w_wr_pend ? bus.wd[NSRC-1:0] : '0) |
                        (w_insvc_load ? r_hw_int : '0)) & r_mode;

   irq_prio_enc #(.NSRC(NSRC)) u_prio_enc (
      .i_req    (w_cand),
      .o_onehot (w_sel),
      .o_valid  (w_valid)
   );

   always_comb begin
      w_state_nxt  = r_state;
      w_hw_nxt     = '0;
      w_insvc_load = 1'b0;
      w_insvc_clr  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_valid) begin
               w_state_nxt = ST_REQ;
               w_hw_nxt    = w_sel;
            end
         end
         ST_REQ: begin
            if (exc_handle) begin
               w_state_nxt  = ST_SVC;
               w_insvc_load = 1'b1;
            end else if (w_valid) begin
               w_hw_nxt = w_sel;
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_SVC: begin
            if (eret) begin
               w_state_nxt = ST_IDLE;
               w_insvc_clr = 1'b1;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mask      <= '0;
         r_mode      <= '0;
         r_pend_edge <= '0;
         r_insvc     <= '0;
         r_irq_q     <= '0;
         r_hw_int    <= '0;
         r_state     <= ST_IDLE;
      end else begin
         r_irq_q     <= irq_in;
         r_state     <= w_state_nxt;
         r_hw_int    <= w_hw_nxt;
         // Set is applied after clear so a coincident rise wins.
         r_pend_edge <= ((r_pend_edge & ~w_pend_clr) | w_pend_set) & r_mode;
         if (w_wr_mask) r_mask <= bus.wd[NSRC-1:0];
         if (w_wr_mode) r_mode <= bus.wd[NSRC-1:0];
         if (w_insvc_load)     r_insvc <= r_hw_int;
         else if (w_insvc_clr) r_insvc <= '0;
      end
   end

   always_comb begin
      bus.rd = '0;
      case (bus.addr)
         ADDR_MASK:  bus.rd[NSRC-1:0] = r_mask;
         ADDR_MODE:  bus.rd[NSRC-1:0] = r_mode;
         ADDR_PEND:  bus.rd[NSRC-1:0] = w_pend;
         ADDR_INSVC: bus.rd[NSRC-1:0] = r_insvc;
         default:    bus.rd = '0;
      endcase
   end

   assign hw_int = r_hw_int;

endmodule

// File: doc/irq_ctrl.md
IRQ_CTRL -- requirements
Module: irq_ctrl

Interface
REQ-001 Parameter NSRC, default 6, SHALL set the number of interrupt sources; it equals the HWInt width of CP0.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 irq_in  input  NSRC  SHALL carry the raw device interrupt lines; bit 0 is the highest priority.
REQ-005 addr  input  2  SHALL select the word register: 0 MASK, 1 MODE, 2 PEND, 3 INSVC.
REQ-006 we  input  1  SHALL be the register write enable.
REQ-007 wd  input  32  SHALL be the write data; only bits [NSRC-1:0] are used.
REQ-008 rd  output  32  SHALL be the read data of the selected register, zero-extended.
REQ-009 exc_handle  input  1  SHALL be CP0's exception-taken pulse.
REQ-010 eret  input  1  SHALL be the ERET-executed pulse.
REQ-011 hw_int  output  NSRC  SHALL be the one-hot interrupt request driven to CP0 HWInt.

Function
REQ-012 The block SHALL register irq_in into irq_q every cycle; a rising edge is irq_in & ~irq_q.
REQ-013 For a source with MODE=1 (edge), PEND SHALL set on the edge where a rising edge is sampled, and it SHALL stay set until cleared.
REQ-014 For a source with MODE=0 (level), PEND SHALL equal irq_q.
REQ-015 A write to PEND SHALL clear edge-mode bits where wd=1 (write-1-to-clear); level bits SHALL ignore the write.
REQ-016 If a set and a clear of the same PEND bit coincide, the set SHALL win.
REQ-017 MASK and MODE SHALL be read/write; INSVC SHALL be read-only, and writes to it SHALL be ignored.
REQ-018 rd SHALL be combinational from addr and the current register values.
REQ-019 The block SHALL implement an FSM with states IDLE, REQ and SVC.
REQ-020 The candidate set SHALL be PEND & MASK; sel SHALL be the lowest-index set bit of the candidate set, as one-hot.
REQ-021 In IDLE, if the candidate set is non-zero, the FSM SHALL go to REQ and register hw_int=sel on the same edge; otherwise hw_int SHALL be 0.
REQ-022 In REQ, hw_int SHALL be re-evaluated every cycle, so a newly pending higher-priority source replaces the current one.
REQ-023 In REQ, if the candidate set becomes empty (level dropped, mask cleared or pending cleared), the FSM SHALL return to IDLE with hw_int=0.
REQ-024 In REQ, exc_handle=1 SHALL cause the FSM to go to SVC, load INSVC with the current hw_int, clear that source's edge PEND bit, and drive hw_int=0.
REQ-025 exc_handle in IDLE or SVC SHALL be ignored (non-interrupt exceptions).
REQ-026 In SVC, hw_int SHALL be 0 and new pending events SHALL still latch.
REQ-027 eret in SVC SHALL clear INSVC and move the FSM to IDLE; if candidates remain, REQ SHALL follow on the next edge.
REQ-028 eret outside SVC SHALL be ignored.
REQ-029 Latency from an edge-mode irq_in rise to hw_int assertion SHALL be 2 clock edges when MASK is set and the FSM is in IDLE.

Reset
REQ-030 While reset=0, the block SHALL asynchronously clear MASK, MODE, PEND, INSVC, irq_q and hw_int to 0, and set the FSM to IDLE.
REQ-031 Reset asserted mid-REQ or mid-SVC SHALL abandon the request or service with no residual pending state.
REQ-032 After release, no hw_int SHALL assert until software writes MASK.

Structure
REQ-033 Register addresses, FSM state encodings and the NSRC default SHALL reside in the shared macro header.
REQ-034 The lowest-index one-hot select SHALL be a sub-module named irq_prio_enc, with a NSRC-wide input, a one-hot output and a valid output.

Verification
REQ-035 Scenario: MASK=0x3F, MODE=0x01, pulse irq_in[0] for one cycle -> hw_int=0x01 two edges later; exc_handle -> hw_int=0, INSVC=0x01, PEND[0]=0; eret -> INSVC=0, IDLE.
REQ-036 Scenario: in REQ with hw_int=0x08, raise irq_in[1] in level mode -> hw_int=0x02 on the following edge; drop irq_in[1] -> hw_int=0x08.
REQ-037 Scenario: edge source 2 rises in the same cycle as a PEND write with wd=0x04 -> PEND[2]=1 (set wins).
REQ-038 Scenario: in SVC, pulse irq_in[4] (edge mode) -> hw_int stays 0; eret -> IDLE, then hw_int=0x10 on the next edge.
REQ-039 Scenario: level source 3 in REQ, clear MASK[3] -> hw_int=0 and IDLE next edge; exc_handle in IDLE -> no state change.
REQ-040 Scenario: assert reset asynchronously mid-SVC -> all registers and hw_int read 0 immediately; irq_in toggling after release -> hw_int=0 until MASK is written.
